// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the MEM-stage access unit
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Size 2'b11 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - store lane steering/byte enables and load extraction/extension
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic        st_we,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata = 32'h0;
        st_be    = 4'b1111;
        if (st_we) begin
            case (st_size)
                SZ_BYTE: begin
                    st_wdata = {4{st_data[7:0]}};
                    st_be    = 4'b0001 << st_off;
                end
                SZ_HALF: begin
                    st_wdata = {2{st_data[15:0]}};
                    st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                end
                default: st_wdata = st_data;
            endcase
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage req/ack data-memory access engine with pipeline stall
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        valid_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        done,
    output logic [31:0] LoadData,
    output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        sgn_q, sgn_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;

    logic        acc;
    logic        trap;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign acc = valid_in & (MemRead | MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap     = is_misaligned(MemSize, Addr[1:0]);
    assign misalign = mis_q;
`else
    assign trap = 1'b0;
`endif

    // Store steering uses the live EX/MEM operands; load extraction uses the latched request.
    mem_lane_align u_lane_align (
        .st_we     (MemWrite),
        .st_size   (MemSize),
        .st_off    (Addr[1:0]),
        .st_data   (StoreData),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_size   (size_q),
        .ld_off    (off_q),
        .ld_signed (sgn_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        off_d   = off_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = acc;
                if (acc && trap) begin
                    state_d = ST_DONE;
                    load_d  = 32'h0;
                    err_d   = 1'b0;
                    mis_d   = 1'b1;
                end else if (acc) begin
                    state_d = ST_BUSY;
                    addr_d  = {Addr[31:2], 2'b00};
                    size_d  = MemSize;
                    off_d   = Addr[1:0];
                    sgn_d   = MemSigned;
                    we_d    = MemWrite;
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    load_d  = 32'h0;
                    err_d   = 1'b0;
                    cnt_d   = 32'h0;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 32'd1;
                if (mem_ack) begin
                    state_d = ST_DONE;
                    load_d  = we_q ? 32'h0 : ld_data;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    load_d  = 32'h0;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                // The instruction leaves MEM at the end of this cycle, so never re-issue.
                state_d = ST_IDLE;
                err_d   = 1'b0;
                mis_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            load_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign mem_req   = (state_q == ST_BUSY);
    assign done      = (state_q == ST_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign LoadData  = load_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with random stimulus and reference model
module tb_mem_access_unit;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        CLR = 1'b1;
    logic        valid_in = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic        MemSigned = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] LoadData;
    logic        bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .valid_in  (valid_in),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .Addr      (Addr),
        .StoreData (StoreData),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .done      (done),
        .LoadData  (LoadData),
        .bus_err   (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        mis;
        int          stalls;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    int n_vec = 0;
    int n_err = 0;

    int          cur_ack_at = 0;
    logic [31:0] cur_rdata = 32'h0;
    logic        ovr = 1'b0;
    logic        ovr_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input int size, input logic [1:0] off,
                                               input logic sgn, input logic [31:0] rd);
        int          bits;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 0) begin
            bits = 8;
            sh   = 8 * int'(off);
        end else if (size == 1) begin
            bits = 16;
            sh   = off[1] ? 16 : 0;
        end else begin
            bits = 32;
            sh   = 0;
        end
        v = rd >> sh;
        if (bits == 32) return v;
        mask = (32'd1 << bits) - 32'd1;
        v = v & mask;
        if (sgn && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bus_t model_bus(input logic wr, input int size, input logic [31:0] addr,
                                       input logic [31:0] sd);
        bus_t b;
        int   off;
        off     = int'(addr[1:0]);
        b.addr  = addr & 32'hFFFF_FFFC;
        b.we    = wr;
        b.be    = 4'hF;
        b.wdata = 32'h0;
        if (wr) begin
            if (size == 0) begin
                b.be    = 4'(1 << off);
                b.wdata = {24'h0, sd[7:0]} * 32'h0101_0101;
            end else if (size == 1) begin
                b.be    = 4'(3 << (off & 2));
                b.wdata = {16'h0, sd[15:0]} * 32'h0001_0001;
            end else begin
                b.wdata = sd;
            end
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ack_at: BUSY cycle (1-based) that carries mem_ack; 0 means the slave never answers.
    task automatic do_op(input logic rd, input logic wr, input int size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_at);
        logic trap;
        res_t r;
        bus_t b;
        bit   seen;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (size == 1 && addr[0]) || (size >= 2 && addr[1:0] != 2'b00);
`endif
        if (!trap) begin
            b = model_bus(wr, size, addr, sd);
            bus_q.push_back(b);
        end
        r.mis    = trap;
        r.err    = !trap && ack_at == 0;
        r.data   = (trap || wr || ack_at == 0) ? 32'h0 : model_load(size, addr[1:0], sgn, rdata);
        r.stalls = trap ? 1 : ((ack_at == 0) ? TO : ack_at) + 1;
        res_q.push_back(r);
        cur_ack_at = ack_at;
        cur_rdata  = rdata;
        valid_in   = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        MemSize    = 2'(size);
        MemSigned  = sgn;
        Addr       = addr;
        StoreData  = sd;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done within 40 cycles for addr %h (expected done)", addr);
        end
        tick();
        valid_in = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Bus slave: counts BUSY cycles, answers on the scheduled one, and sprays stray acks otherwise.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ovr) begin
                mem_ack   = ovr_ack;
                mem_rdata = $urandom();
            end else if (mem_req) begin
                busy_cnt++;
                mem_ack   = (busy_cnt == cur_ack_at);
                mem_rdata = mem_ack ? cur_rdata : $urandom();
            end else begin
                busy_cnt  = 0;
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom();
            end
        end
    end

    initial begin
        int   stall_cnt;
        bit   req_seen;
        bit   cur_ok;
        bit   prev_done;
        bus_t cur;
        res_t r;
        stall_cnt = 0;
        req_seen  = 0;
        cur_ok    = 0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) begin
                if (!req_seen) begin
                    req_seen = 1;
                    cur_ok   = bus_q.size() != 0;
                    if (cur_ok) begin
                        cur = bus_q.pop_front();
                    end else begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_req: mem_req=1 addr %h with no access pending (expected 0)", mem_addr);
                    end
                end
                if (cur_ok) begin
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_be", 32'(mem_be), 32'(cur.be));
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end else begin
                req_seen = 0;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: done=1 with no access pending (expected 0)");
                end else begin
                    r = res_q.pop_front();
                    chk("LoadData", LoadData, r.data);
                    chk("bus_err", 32'(bus_err), 32'(r.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("misalign", 32'(misalign), 32'(r.mis));
`endif
                end
                if (prev_done) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done_width: done high 2 cycles in a row (expected 1)");
                end
                stall_cnt = 0;
            end
            if (CLR) stall_cnt = 0;
            prev_done = done;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_stall"}, 32'(stall), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_LoadData"}, LoadData, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk({tag, "_misalign"}, 32'(misalign), 32'h0);
`endif
    endtask

    initial begin
        int          kind;
        logic [31:0] a;
        CLR = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        CLR = 1'b0;
        tick();

        do_op(1'b1, 1'b0, 0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        do_op(1'b0, 1'b1, 1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, $urandom(), 1);
        do_op(1'b1, 1'b0, 2, 1'b0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 5);
        do_op(1'b1, 1'b0, 2, 1'b0, 32'h0000_5000, 32'h0, 32'h1111_2222, 0);
        do_op(1'b1, 1'b0, 2, 1'b0, 32'h0000_3001, 32'h0, 32'hA5A5_5A5A, 1);
        do_op(1'b1, 1'b0, 1, 1'b1, 32'h0000_0012, 32'h0, 32'h8765_4321, 2);

        // Flush in the 2nd BUSY cycle with a coincident ack, then an ack right after the flush.
        bus_q.push_back(model_bus(1'b0, 2, 32'h0000_0040, 32'h0));
        cur_ack_at = 0;
        valid_in   = 1'b1;
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        MemSize    = 2'b10;
        MemSigned  = 1'b0;
        Addr       = 32'h0000_0040;
        tick();
        ovr     = 1'b1;
        ovr_ack = 1'b1;
        tick();
        CLR = 1'b1;
        tick();
        CLR      = 1'b0;
        valid_in = 1'b0;
        MemRead  = 1'b0;
        #1;
        chk_all_zero("clr");
        for (int i = 0; i < 3; i++) begin
            tick();
            ovr = 1'b0;
            chk("clr_no_req", 32'(mem_req), 32'h0);
            chk("clr_no_done", 32'(done), 32'h0);
        end

        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom();
            if (kind == 4) begin
                valid_in = $urandom_range(0, 1) == 1;
                MemRead  = valid_in ? 1'b0 : 1'($urandom_range(0, 1));
                MemWrite = valid_in ? 1'b0 : 1'($urandom_range(0, 1));
                Addr     = a;
                #1;
                chk("bubble_stall", 32'(stall), 32'h0);
                tick();
                chk("bubble_no_req", 32'(mem_req), 32'h0);
                valid_in = 1'b0;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end else begin
                do_op(kind <= 1, kind >= 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      a, $urandom(), $urandom(), $urandom_range(0, TO));
            end
        end

        tick();
        tick();
        chk("queue_bus_drained", 32'(bus_q.size()), 32'h0);
        chk("queue_res_drained", 32'(res_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine. Sits between the EX/MEM pipeline register and MEMtoWB.
- Turns a load/store micro-op into a req/ack transaction on the external data-memory bus, with byte-lane steering and load sign/zero extension.
- Stalls the front of the pipeline while the bus is busy.
- The load result feeds the R2 input of the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ack before abort with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- CLR  in  1  synchronous active-high reset/flush. Same polarity and timing as the pipeline-register CLR.
- valid_in  in  1  instruction-present bit from EX/MEM (0 = bubble).
- MemRead  in  1  load request.
- MemWrite  in  1  store request. MemRead and MemWrite are never both 1; if they are, MemWrite wins.
- MemSize  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- MemSigned  in  1  1 = sign-extend loads, 0 = zero-extend.
- Addr  in  32  byte address from the ALU.
- StoreData  in  32  rt value; the low bits hold the datum.
- mem_req  out  1  bus request, held high until accepted.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, Addr with bits [1:0] forced to 00.
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle acceptance/completion strobe.
- stall  out  1  freeze PC/IF/ID/EX and EX/MEM; insert bubble into MEMtoWB.
- done  out  1  access complete this cycle; MEMtoWB captures this cycle.
- LoadData  out  32  extended load result, stable while done=1.
- bus_err  out  1  timeout abort; meaningful only with done=1.

Behaviour:
- Access condition: acc = valid_in & (MemRead | MemWrite).
- State machine with three states: IDLE, BUSY, DONE.
- IDLE:
  - acc=1: latch Addr, MemSize, MemSigned, mem_we and steered data; go BUSY.
  - stall = acc, combinational.
  - acc=0: remain IDLE; stall=0; done=0.
- BUSY:
  - mem_req=1; stall=1; timeout counter increments each cycle.
  - mem_ack=1: capture the extended mem_rdata into LoadData (stores keep LoadData 0); go DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: bus_err=1, LoadData=0, go DONE.
- DONE:
  - stall=0; done=1; mem_req=0.
  - Always go IDLE next cycle; the instruction advances at the end of DONE, so no re-issue.
- Minimum latency: ack in the first BUSY cycle gives 3 cycles in MEM (2 stall cycles).
- Bus outputs come from the latched copy only; they are stable throughout BUSY.
- mem_ack while not in BUSY is ignored.
- Store lane steering, where a = Addr[1:0]:
  - byte: wdata = {4{SD[7:0]}}, be = 0001<<a.
  - half: wdata = {2{SD[15:0]}}, be = a[1] ? 1100 : 0011.
  - word: wdata = SD, be = 1111.
- Loads:
  - mem_be = 1111.
  - byte: lane a.
  - half: upper half if a[1], else lower half.
  - word: whole word.
  - Extend to 32 bits per MemSigned.
- Misalignment (default build): offending low bits are ignored. Half ignores a[0]; word ignores a[1:0].
- CLR:
  - Any state goes to IDLE.
  - stall, done, mem_req, mem_we, bus_err = 0; mem_be = 0; mem_addr, mem_wdata, LoadData = 0; timeout counter = 0.
  - A mem_ack arriving in the cycle after CLR is ignored.
- CLR has priority over every other event, including a coincident mem_ack.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Half with a[0]=1, or word with a≠00, skips the bus entirely: IDLE → DONE in one cycle, no mem_req.
  - Adds output misalign (1 bit), asserted with done; LoadData=0, no write issued.
  - misalign resets to 0 on CLR.
- Undefined: no misalign port; silent alignment as above.

Decomposition:
- Shared package:
  - MemSize encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - State encodings ST_IDLE/ST_BUSY/ST_DONE.
- Sub-module mem_lane_align (combinational):
  - store steering and mem_be generation.
  - load extraction and extension.
  - Instantiated once.

Test Plan:
- Load: byte signed, Addr=0x1003, mem_rdata=0x80FF_1234, ack on first BUSY cycle -> mem_addr=0x1000; LoadData=0xFFFF_FF80; stall high 2 cycles; done 1 cycle.
- Store: half, Addr=0x2002, StoreData=0x0000_BEEF -> mem_we=1; mem_be=1100; mem_wdata=0xBEEF_BEEF; LoadData=0.
- Load: word unsigned, ack delayed 5 cycles -> mem_req held 5 cycles with stable addr; done exactly one cycle after ack.
- TIMEOUT_CYCLES=4, no ack -> bus_err=1 with done after 4 BUSY cycles; mem_req then drops.
- CLR asserted in the 2nd BUSY cycle, then ack -> IDLE; all outputs 0; ack ignored; no done pulse.
- With MEM_MISALIGN_TRAP_EN defined: word load at Addr=0x3001 -> no mem_req; misalign=1 and done=1 on the cycle after presentation.
